// File: rtl/i2c_slave_if.sv
// Local-side byte handshake between i2c_slave and the user logic that
// supplies read bytes and consumes written bytes.
interface i2c_slave_if;
   logic [7:0] data_in_top;
   logic       tx_valid;
   logic [7:0] data_out;
   logic       data_valid;
   logic       rd_req;
   logic       busy;

   modport slave (
      input  data_in_top, tx_valid,
      output data_out, data_valid, rd_req, busy
   );

   modport master (
      output data_in_top, tx_valid,
      input  data_out, data_valid, rd_req, busy
   );
endinterface

// File: rtl/i2c_slave.sv
// I2C target oversampled in the clk domain: START/STOP decode, 7-bit address match,
// byte write/read. Define I2C_SLAVE_STRETCH_EN to stretch SCL until tx_valid on read loads.
module i2c_slave #(
   parameter logic [6:0]  SLAVE_ADDR  = 7'h42,
   parameter int unsigned SYNC_STAGES = 2
) (
   input  logic       clk,
   input  logic       rst,
   i2c_slave_if.slave lif,
   inout  wire        sda,
   inout  wire        scl
);
   localparam logic [2:0] IDLE      = 3'd0;
   localparam logic [2:0] ADDR      = 3'd1;
   localparam logic [2:0] ADDR_ACK  = 3'd2;
   localparam logic [2:0] WR_DATA   = 3'd3;
   localparam logic [2:0] WR_ACK    = 3'd4;
   localparam logic [2:0] RD_DATA   = 3'd5;
   localparam logic [2:0] RD_ACK    = 3'd6;
   localparam logic [2:0] WAIT_STOP = 3'd7;

   logic [SYNC_STAGES-1:0] scl_sync_q, sda_sync_q;
   logic                   scl_prev_q, sda_prev_q;
   logic                   scl_s, sda_s, scl_rise, scl_fall, start_c, stop_c;

   logic [2:0] state_q, state_d;
   logic [3:0] cnt_q, cnt_d;
   logic [7:0] shift_q, shift_d;
   logic [7:0] data_out_q, data_out_d;
   logic       rw_q, rw_d;
   logic       busy_q, busy_d;
   logic       sda_oe_q, sda_oe_d;
   logic       dv_q, dv_d;
   logic       rd_req_q, rd_req_d;
   logic       load_pt, do_load;

`ifdef I2C_SLAVE_STRETCH_EN
   logic ld_pend_q, ld_pend_d;
   logic scl_oe_q, scl_oe_d;
`endif

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         scl_sync_q <= '1;
         sda_sync_q <= '1;
         scl_prev_q <= 1'b1;
         sda_prev_q <= 1'b1;
      end else begin
         scl_sync_q <= {scl_sync_q[SYNC_STAGES-2:0], scl};
         sda_sync_q <= {sda_sync_q[SYNC_STAGES-2:0], sda};
         scl_prev_q <= scl_s;
         sda_prev_q <= sda_s;
      end
   end

   assign scl_s    = scl_sync_q[SYNC_STAGES-1];
   assign sda_s    = sda_sync_q[SYNC_STAGES-1];
   assign scl_rise = scl_s & ~scl_prev_q;
   assign scl_fall = ~scl_s & scl_prev_q;
   assign start_c  = scl_s & scl_prev_q & sda_prev_q & ~sda_s;
   assign stop_c   = scl_s & scl_prev_q & ~sda_prev_q & sda_s;

   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      shift_d    = shift_q;
      data_out_d = data_out_q;
      rw_d       = rw_q;
      busy_d     = busy_q;
      sda_oe_d   = sda_oe_q;
      dv_d       = 1'b0;
      rd_req_d   = 1'b0;
      load_pt    = 1'b0;
      do_load    = 1'b0;
`ifdef I2C_SLAVE_STRETCH_EN
      ld_pend_d  = ld_pend_q;
      // SCL stays low through the load cycle and is released one clk later
      scl_oe_d   = scl_oe_q & ld_pend_q;
`endif

      if (start_c) begin
         state_d  = ADDR;
         cnt_d    = '0;
         sda_oe_d = 1'b0;
`ifdef I2C_SLAVE_STRETCH_EN
         ld_pend_d = 1'b0;
         scl_oe_d  = 1'b0;
`endif
      end else if (stop_c) begin
         state_d  = IDLE;
         sda_oe_d = 1'b0;
         busy_d   = 1'b0;
`ifdef I2C_SLAVE_STRETCH_EN
         ld_pend_d = 1'b0;
         scl_oe_d  = 1'b0;
`endif
      end else begin
         case (state_q)
            ADDR: begin
               if (scl_rise) begin
                  shift_d = {shift_q[6:0], sda_s};
                  cnt_d   = cnt_q + 4'd1;
                  if (cnt_q == 4'd7) begin
                     rw_d = sda_s;
                     if (shift_q[6:0] != SLAVE_ADDR) state_d = WAIT_STOP;
                  end
               end else if (scl_fall && cnt_q == 4'd8) begin
                  sda_oe_d = 1'b1;
                  busy_d   = 1'b1;
                  state_d  = ADDR_ACK;
               end
            end
            ADDR_ACK: begin
               if (scl_fall) begin
                  if (!rw_q) begin
                     sda_oe_d = 1'b0;
                     cnt_d    = '0;
                     state_d  = WR_DATA;
                  end else begin
                     load_pt = 1'b1;
                  end
               end
            end
            WR_DATA: begin
               if (scl_rise) begin
                  shift_d = {shift_q[6:0], sda_s};
                  cnt_d   = cnt_q + 4'd1;
                  if (cnt_q == 4'd7) begin
                     data_out_d = {shift_q[6:0], sda_s};
                     dv_d       = 1'b1;
                  end
               end else if (scl_fall && cnt_q == 4'd8) begin
                  sda_oe_d = 1'b1;
                  state_d  = WR_ACK;
               end
            end
            WR_ACK: begin
               if (scl_fall) begin
                  sda_oe_d = 1'b0;
                  cnt_d    = '0;
                  state_d  = WR_DATA;
               end
            end
            RD_DATA: begin
               if (scl_rise) begin
                  cnt_d = cnt_q + 4'd1;
               end else if (scl_fall) begin
                  if (cnt_q == 4'd8) begin
                     sda_oe_d = 1'b0;
                     state_d  = RD_ACK;
                  end else begin
                     shift_d  = {shift_q[6:0], 1'b0};
                     sda_oe_d = ~shift_q[6];
                  end
               end
            end
            RD_ACK: begin
               // cnt 9 marks a sampled master ACK awaiting the next falling edge
               if (scl_rise) begin
                  if (sda_s) state_d = WAIT_STOP;
                  else       cnt_d   = 4'd9;
               end else if (scl_fall && cnt_q == 4'd9) begin
                  load_pt = 1'b1;
               end
            end
            default: ;
         endcase
      end

`ifdef I2C_SLAVE_STRETCH_EN
      do_load = (load_pt | ld_pend_q) & lif.tx_valid;
      if (load_pt && !lif.tx_valid) begin
         ld_pend_d = 1'b1;
         scl_oe_d  = 1'b1;
      end else if (do_load) begin
         ld_pend_d = 1'b0;
      end
`else
      do_load = load_pt;
`endif

      if (do_load) begin
         rd_req_d = 1'b1;
         shift_d  = lif.data_in_top;
         sda_oe_d = ~lif.data_in_top[7];
         cnt_d    = '0;
         state_d  = RD_DATA;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q    <= IDLE;
         cnt_q      <= '0;
         shift_q    <= '0;
         data_out_q <= '0;
         rw_q       <= 1'b0;
         busy_q     <= 1'b0;
         sda_oe_q   <= 1'b0;
         dv_q       <= 1'b0;
         rd_req_q   <= 1'b0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         shift_q    <= shift_d;
         data_out_q <= data_out_d;
         rw_q       <= rw_d;
         busy_q     <= busy_d;
         sda_oe_q   <= sda_oe_d;
         dv_q       <= dv_d;
         rd_req_q   <= rd_req_d;
      end
   end

`ifdef I2C_SLAVE_STRETCH_EN
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         ld_pend_q <= 1'b0;
         scl_oe_q  <= 1'b0;
      end else begin
         ld_pend_q <= ld_pend_d;
         scl_oe_q  <= scl_oe_d;
      end
   end

   assign scl = scl_oe_q ? 1'b0 : 1'bz;
`else
   logic unused_tx_valid;
   assign unused_tx_valid = lif.tx_valid;
   assign scl = 1'bz;
`endif

   assign sda            = sda_oe_q ? 1'b0 : 1'bz;
   assign lif.data_out   = data_out_q;
   assign lif.data_valid = dv_q;
   assign lif.rd_req     = rd_req_q;
   assign lif.busy       = busy_q;
endmodule

// File: tb/tb_i2c_slave.sv
// Bench for i2c_slave: a bit-banged bus master with randomized addresses and bytes,
// checked against transaction-level expectations kept in the bench.
module tb_i2c_slave;
   localparam logic [6:0] ADDR = 7'h42;

   logic clk = 1'b0;
   logic rst;
   logic m_sda_oe = 1'b0;
   logic m_scl_oe = 1'b0;
   wire  sda, scl;

   pullup (sda);
   pullup (scl);
   assign sda = m_sda_oe ? 1'b0 : 1'bz;
   assign scl = m_scl_oe ? 1'b0 : 1'bz;

   i2c_slave_if lif ();

   i2c_slave #(.SLAVE_ADDR(ADDR), .SYNC_STAGES(2)) dut (
      .clk (clk),
      .rst (rst),
      .lif (lif),
      .sda (sda),
      .scl (scl)
   );

   always #5 clk = ~clk;

   int unsigned n_checks = 0, n_pass = 0, n_fail = 0;
   int unsigned dv_cnt = 0, rd_cnt = 0, both_cnt = 0;
   int unsigned tgt_scl_low = 0, stretch_run = 0, stretch_max = 0;
   time         rd_time = 0, tv_time = 0;
   logic        m_scl_prev = 1'b0;

   // reference expectations, updated per transaction
   logic [7:0]  exp_data_out = 8'h00;
   int unsigned exp_dv = 0, exp_rd = 0;

   always @(negedge clk) begin
      if (lif.data_valid) dv_cnt++;
      if (lif.rd_req) begin
         rd_cnt++;
         rd_time = $time;
      end
      if (lif.data_valid && lif.rd_req) both_cnt++;
      if (scl === 1'b0 && !m_scl_oe && !m_scl_prev) begin
         tgt_scl_low++;
         stretch_run++;
         if (stretch_run > stretch_max) stretch_max = stretch_run;
      end else begin
         stretch_run = 0;
      end
      m_scl_prev = m_scl_oe;
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) n_pass++;
      else begin
         n_fail++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic tick(input int unsigned n);
      repeat (n) @(negedge clk);
   endtask

   task automatic scl_up();
      m_scl_oe = 1'b0;
      for (int i = 0; i < 400 && scl !== 1'b1; i++) @(negedge clk);
      check("scl_high_within_bound", {31'd0, scl}, 32'd1);
   endtask

   task automatic wr_bit(input logic b);
      m_sda_oe = ~b;
      tick(4);
      scl_up();
      tick(8);
      m_scl_oe = 1'b1;
      tick(4);
   endtask

   task automatic rd_bit(output logic b);
      m_sda_oe = 1'b0;
      tick(4);
      scl_up();
      tick(4);
      b = sda;
      tick(4);
      m_scl_oe = 1'b1;
      tick(4);
   endtask

   task automatic start_c();
      m_sda_oe = 1'b0;
      tick(4);
      scl_up();
      tick(4);
      m_sda_oe = 1'b1;
      tick(4);
      m_scl_oe = 1'b1;
      tick(4);
   endtask

   task automatic stop_c();
      m_sda_oe = 1'b1;
      tick(4);
      scl_up();
      tick(4);
      m_sda_oe = 1'b0;
      tick(8);
   endtask

   task automatic wr_byte(input logic [7:0] d, output logic ack);
      for (int i = 7; i >= 0; i--) wr_bit(d[i]);
      rd_bit(ack);
   endtask

   task automatic rd_byte(output logic [7:0] d);
      logic b;
      d = 8'h00;
      for (int i = 0; i < 8; i++) begin
         rd_bit(b);
         d = {d[6:0], b};
      end
   endtask

   task automatic do_write(input logic [6:0] a, input int unsigned n, input logic [7:0] first);
      logic       ack, hit;
      logic [7:0] d;
      hit = (a == ADDR);
      start_c();
      wr_byte({a, 1'b0}, ack);
      check("wr_addr_ack", ack, !hit);
      check("wr_busy", lif.busy, hit);
      for (int unsigned k = 0; k < n; k++) begin
         d = (k == 0) ? first : 8'($urandom);
         wr_byte(d, ack);
         if (hit) begin
            exp_data_out = d;
            exp_dv++;
         end
         check("wr_data_ack", ack, !hit);
         check("wr_data_out", lif.data_out, exp_data_out);
         check("wr_dv_count", dv_cnt, exp_dv);
      end
      stop_c();
      check("wr_busy_after_stop", lif.busy, 1'b0);
   endtask

   task automatic do_read(input logic [7:0] b0, input logic [7:0] b1, input int unsigned n);
      logic       ack;
      logic [7:0] d, want;
      want = b0;
      lif.data_in_top = b0;
      start_c();
      wr_byte({ADDR, 1'b1}, ack);
      check("rd_addr_ack", ack, 1'b0);
      for (int unsigned k = 0; k < n; k++) begin
         rd_byte(d);
         exp_rd++;
         check("rd_byte", d, want);
         check("rd_req_count", rd_cnt, exp_rd);
         if (k + 1 < n) begin
            want = (k == 0) ? b1 : 8'($urandom);
            lif.data_in_top = want;
            wr_bit(1'b0);
         end else begin
            wr_bit(1'b1);
         end
      end
      tick(4);
      check("rd_sda_released_after_nack", sda, 1'b1);
      stop_c();
      check("rd_busy_after_stop", lif.busy, 1'b0);
      check("rd_no_data_valid", dv_cnt, exp_dv);
   endtask

   initial begin
      #5_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic       ack;
      logic [6:0] a;
      logic [7:0] d, sb, rb;

      rst = 1'b0;
      lif.data_in_top = 8'h00;
`ifdef I2C_SLAVE_STRETCH_EN
      lif.tx_valid = 1'b1;
`else
      lif.tx_valid = 1'b0;
`endif
      tick(3);
      check("reset_busy", lif.busy, 1'b0);
      check("reset_data_out", lif.data_out, 8'h00);
      check("reset_data_valid", lif.data_valid, 1'b0);
      check("reset_rd_req", lif.rd_req, 1'b0);
      check("reset_sda", sda, 1'b1);
      check("reset_scl", scl, 1'b1);
      rst = 1'b1;
      tick(5);

      do_write(ADDR, 1, 8'h5A);
      check("write_5a", lif.data_out, 8'h5A);

      for (int unsigned t = 0; t < 4; t++) begin
         a = 7'($urandom);
         if ($urandom_range(0, 1) == 1) a = ADDR;
         else if (a == ADDR) a = ~ADDR;
         do_write(a, $urandom_range(1, 3), 8'($urandom));
      end

      do_write(7'h43, 1, 8'hA5);
      check("miss_keeps_data_out", lif.data_out, exp_data_out);

      do_read(8'hC3, 8'h3C, 2);
      do_read(8'($urandom), 8'($urandom), $urandom_range(1, 3));

      // repeated START: write then read without an intervening STOP
      start_c();
      wr_byte(8'h84, ack);
      check("rs_addr_ack", ack, 1'b0);
      d = 8'($urandom);
      wr_byte(d, ack);
      exp_data_out = d;
      exp_dv++;
      check("rs_data_ack", ack, 1'b0);
      sb = 8'($urandom);
      lif.data_in_top = sb;
      start_c();
      wr_byte(8'h85, ack);
      check("rs_read_addr_ack", ack, 1'b0);
      rd_byte(rb);
      exp_rd++;
      check("rs_read_byte", rb, sb);
      check("rs_rd_req_count", rd_cnt, exp_rd);
      check("rs_data_out", lif.data_out, exp_data_out);
      check("rs_dv_count", dv_cnt, exp_dv);
      wr_bit(1'b1);
      stop_c();

      // STOP in the middle of a data byte discards it
      start_c();
      wr_byte(8'h84, ack);
      check("midstop_addr_ack", ack, 1'b0);
      for (int i = 0; i < 4; i++) wr_bit(1'($urandom));
      stop_c();
      check("midstop_dv_count", dv_cnt, exp_dv);
      check("midstop_data_out", lif.data_out, exp_data_out);
      check("midstop_busy", lif.busy, 1'b0);

`ifdef I2C_SLAVE_STRETCH_EN
      sb = 8'($urandom);
      lif.data_in_top = sb;
      lif.tx_valid = 1'b0;
      start_c();
      wr_byte(8'h85, ack);
      check("stretch_addr_ack", ack, 1'b0);
      fork
         begin
            tick(50);
            lif.tx_valid = 1'b1;
            tv_time = $time;
         end
      join_none
      rd_byte(rb);
      exp_rd++;
      check("stretch_byte", rb, sb);
      check("stretch_rd_req_count", rd_cnt, exp_rd);
      check("stretch_scl_held_40", {31'd0, stretch_max >= 40}, 32'd1);
      check("stretch_rd_req_latency", 32'((rd_time - tv_time) / 10), 32'd1);
      wr_bit(1'b1);
      stop_c();
`else
      // tx_valid low must not stall a read in the default build
      lif.tx_valid = 1'b0;
      do_read(8'($urandom), 8'($urandom), 2);
      check("no_stretch_scl_never_low", tgt_scl_low, 0);
`endif

      // asynchronous reset during the 4th bit of a data byte
      start_c();
      wr_byte(8'h84, ack);
      check("rst_addr_ack", ack, 1'b0);
      check("rst_busy_before", lif.busy, 1'b1);
      wr_bit(1'b1);
      wr_bit(1'b0);
      wr_bit(1'b1);
      m_sda_oe = 1'b0;
      tick(4);
      scl_up();
      tick(2);
      rst = 1'b0;
      tick(1);
      m_sda_oe = 1'b0;
      m_scl_oe = 1'b0;
      exp_data_out = 8'h00;
      tick(1);
      check("rst_mid_busy", lif.busy, 1'b0);
      check("rst_mid_data_out", lif.data_out, 8'h00);
      check("rst_mid_sda", sda, 1'b1);
      check("rst_mid_scl", scl, 1'b1);
      check("rst_mid_dv_count", dv_cnt, exp_dv);
      rst = 1'b1;
      tick(10);
      do_write(ADDR, 2, 8'($urandom));

      check("dv_rd_req_exclusive", both_cnt, 0);
      check("final_rd_req_count", rd_cnt, exp_rd);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end
endmodule

// File: doc/i2c_slave.md
Name: i2c_slave

Overview:
- I2C target (responder): decodes START/STOP, matches a 7-bit address, and accepts written bytes or serves read bytes over open-drain SDA/SCL.
- Answers the team's I2C master on the same bus and hands bytes to and from local logic through a simple pulse/strobe interface.
- Oversamples the bus with the system clock. All logic is in the clk domain; no logic runs on SCL.

Parameters:
- SLAVE_ADDR, 7'h42, 7-bit bus address this target responds to.
- SYNC_STAGES, 2, synchronizer flops on the SCL/SDA inputs (minimum 2).

Ports:
- clk  in  1  system clock; must be at least 8x the SCL frequency.
- rst  in  1  asynchronous, active-low reset.
- data_in_top  in  8  byte returned to the master on a read; sampled in the rd_req cycle.
- tx_valid  in  1  data_in_top is available. Used only with I2C_SLAVE_STRETCH_EN.
- data_out  out  8  last byte written by the master.
- data_valid  out  1  one-clk pulse when data_out is updated.
- rd_req  out  1  one-clk pulse when a read byte is loaded.
- busy  out  1  high from an address-matched START until STOP.
- sda  inout  1  open-drain: driven 0 or released to z.
- scl  inout  1  open-drain: released to z, except it is driven 0 while stretching.

Behaviour:
- Reset (rst=0, asynchronous):
  - state=IDLE; data_out=0; data_valid=0; rd_req=0; busy=0.
  - sda and scl released; synchronizers set to 1.
- Input path: SCL/SDA pass through SYNC_STAGES flops, then edge detection. Bus events therefore act SYNC_STAGES+1 clk after the pin changes.
- Bus conditions (checked in every state, including mid-byte; they take priority over bit processing):
  - START = SDA falling while SCL high. It clears the bit counter, goes to ADDR, and is also a repeated START.
  - STOP = SDA rising while SCL high. It goes to IDLE, releases SDA, and clears busy.
- Bit timing, MSB first:
  - Sample SDA on the synchronized SCL rising edge.
  - Change the driven SDA only on the synchronized SCL falling edge.
- States:
  - IDLE: wait for START.
  - ADDR: shift 8 bits {addr, rw}. On the 8th rising edge, compare addr with SLAVE_ADDR.
    - Match: on the next falling edge, drive SDA=0 and go to ADDR_ACK; busy=1.
    - Mismatch: go to WAIT_STOP and keep SDA released.
  - ADDR_ACK: hold SDA=0 through the ACK clock. On the following falling edge:
    - rw=0: release SDA and go to WR_DATA.
    - rw=1: pulse rd_req, load data_in_top into the shift register, drive bit7, and go to RD_DATA.
  - WR_DATA: shift 8 bits. On the 8th rising edge, data_out is updated and data_valid pulses once. On the next falling edge, drive ACK (0) and go to WR_ACK.
  - WR_ACK: on the following falling edge, release SDA and return to WR_DATA. Every written byte is ACKed.
  - RD_DATA: drive bits 7..0. After the 8th bit, on its falling edge, release SDA and go to RD_ACK.
  - RD_ACK: sample the master's ACK on the rising edge.
    - ACK (0): on the next falling edge, pulse rd_req, load the next byte, and go to RD_DATA.
    - NACK (1): go to WAIT_STOP with SDA released.
  - WAIT_STOP: ignore bits until START or STOP.
- SDA is never driven in IDLE or WAIT_STOP.
- data_valid and rd_req never assert in the same cycle.
- data_out holds its value until the next completed write byte.
- A STOP or START mid-byte discards the partial byte: no data_valid is issued.

Optional Feature:
- Macro: I2C_SLAVE_STRETCH_EN.
- Defined: at each rd_req point, if tx_valid=0, hold scl=0 (drive low) after the falling edge. rd_req and the load are delayed until the first clk with tx_valid=1. The target then loads the byte, drives bit7, and releases scl 1 clk later.
- Not defined: tx_valid is ignored, scl is never driven (permanently z), and data_in_top is sampled unconditionally at rd_req.

Test Plan:
- Reset: assert rst=0 mid-transfer (during the 4th WR_DATA bit) -> sda and scl immediately z, busy=0, data_out=0; after release, the next START + 0x84 write is ACKed normally.
- Write 0x5A to 0x42 (SCL period 16 clk) -> ACK after the address, data_out=0x5A with a single data_valid pulse, ACK after the data; STOP -> busy=0.
- Address 0x43 write -> SDA stays z (NACK); no data_valid; busy stays 0 until STOP.
- Read from 0x42 with data_in_top=0xC3, then 0x3C, master ACK then NACK -> bytes 0xC3 and 0x3C on SDA; rd_req pulses twice; target releases SDA after the NACK.
- Repeated START: write 0x11, then START without STOP, then read address 0x85 -> data_out=0x11; rd_req pulses; the read byte is served.
- Stretch (I2C_SLAVE_STRETCH_EN defined): read with tx_valid=0 for 40 clk -> scl held low for at least 40 clk; rd_req fires the cycle tx_valid rises; byte is correct. Macro undefined: scl never driven low by the target.
